// File: rtl/song_sequencer.sv
// Chord-sequence player: steps through a parameter ROM of voice masks, square-wave tone per active voice, silent gap per step.
// Optional build macro SONG_SEQUENCER_LOOP_EN: repeat the song from step 0 instead of returning to idle.
module song_sequencer #(
  parameter int NUM_VOICES = 8,
  parameter int SONG_LEN = 9,
  parameter logic [NUM_VOICES*SONG_LEN-1:0] SONG_DATA = 72'hA8_01_02_01_08_20_40_20_A8,
  parameter int HP_W = 17,
  parameter logic [NUM_VOICES*HP_W-1:0] HALF_PERIODS = {17'd95556, 17'd85131, 17'd75843, 17'd71586,
                                                        17'd63776, 17'd56818, 17'd50619, 17'd47778},
  parameter int STEP_TICKS = 12_500_000,
  parameter int GAP_TICKS = 625_000,
  parameter int TW = 24
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              play_btn,
  output logic [NUM_VOICES-1:0]             speaker,
  output logic                              busy,
  output logic [$clog2(SONG_LEN+1)-1:0]     step_idx
);

  localparam int SW = $clog2(SONG_LEN + 1);
  localparam int ROM_N = 1 << SW;
  localparam logic [TW-1:0] NOTE_LAST = TW'(STEP_TICKS - GAP_TICKS - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_TICKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NOTE = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  if (SONG_LEN < 1) begin : g_bad_len
    $error("song_sequencer: SONG_LEN must be at least 1");
  end
  if (GAP_TICKS <= 0 || GAP_TICKS >= STEP_TICKS) begin : g_bad_gap
    $error("song_sequencer: GAP_TICKS must lie strictly between 0 and STEP_TICKS");
  end
  if ((64'd1 << TW) <= 64'(STEP_TICKS)) begin : g_bad_tw
    $error("song_sequencer: TW too narrow for STEP_TICKS");
  end

  logic [1:0]            state_reg;
  logic                  btn_q;
  logic [TW-1:0]         timer_reg;
  logic [SW-1:0]         step_reg;
  logic [NUM_VOICES-1:0] mask_reg;
  logic [NUM_VOICES-1:0] song_rom [ROM_N];

  // ROM padded to a power of two so the step index addresses it exactly; spare entries are rests.
  for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
    if (gi < SONG_LEN) begin : g_used
      assign song_rom[gi] = SONG_DATA[(SONG_LEN-gi)*NUM_VOICES-1 -: NUM_VOICES];
    end else begin : g_pad
      assign song_rom[gi] = '0;
    end
  end

  logic rise;
  logic note_end;
  logic gap_end;
  logic last_step;
  logic tone_run;

  assign rise      = play_btn & ~btn_q;
  assign note_end  = (state_reg == NOTE) && (timer_reg == NOTE_LAST);
  assign gap_end   = (state_reg == GAP) && (timer_reg == STEP_LAST);
  assign last_step = (step_reg == SW'(SONG_LEN - 1));
  // Tones only advance on NOTE cycles that stay in NOTE; every other cycle forces them silent and cleared.
  assign tone_run  = (state_reg == NOTE) && !rise && !note_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      btn_q     <= 1'b0;
      timer_reg <= '0;
      step_reg  <= '0;
      mask_reg  <= '0;
    end else begin
      btn_q <= play_btn;
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_reg <= NOTE;
            timer_reg <= '0;
            step_reg  <= '0;
            mask_reg  <= song_rom[0];
          end
        end
        NOTE: begin
          if (rise) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            step_reg  <= '0;
          end else begin
            if (note_end) state_reg <= GAP;
            timer_reg <= timer_reg + TW'(1);
          end
        end
        GAP: begin
          if (rise) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            step_reg  <= '0;
          end else if (gap_end) begin
            timer_reg <= '0;
            if (!last_step) begin
              state_reg <= NOTE;
              step_reg  <= step_reg + SW'(1);
              mask_reg  <= song_rom[step_reg + SW'(1)];
            end else begin
`ifdef SONG_SEQUENCER_LOOP_EN
              state_reg <= NOTE;
              step_reg  <= '0;
              mask_reg  <= song_rom[0];
`else
              state_reg <= IDLE;
              step_reg  <= '0;
`endif
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          timer_reg <= '0;
          step_reg  <= '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIODS[gi*HP_W +: HP_W] - 1);
    logic [HP_W-1:0] cnt_reg;
    logic            spk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
        spk_reg <= 1'b0;
      end else if (!tone_run || !mask_reg[gi]) begin
        cnt_reg <= '0;
        spk_reg <= 1'b0;
      end else if (cnt_reg == HP_LAST) begin
        cnt_reg <= '0;
        spk_reg <= ~spk_reg;
      end else begin
        cnt_reg <= cnt_reg + HP_W'(1);
      end
    end

    assign speaker[gi] = spk_reg;
  end

  assign busy     = (state_reg != IDLE);
  assign step_idx = step_reg;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a closed-form playback model predicts each cycle's outputs.
module tb_song_sequencer;

`ifdef SONG_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int STEP = 20;
  localparam int GAP = 4;
  localparam int NSTEPS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play_btn = 1'b0;
  logic [1:0] speaker;
  logic       busy;
  logic [1:0] step_idx;

  song_sequencer #(
    .NUM_VOICES(2),
    .SONG_LEN(3),
    .SONG_DATA(6'b11_01_10),
    .HP_W(17),
    .HALF_PERIODS({17'd3, 17'd2}),
    .STEP_TICKS(20),
    .GAP_TICKS(4),
    .TW(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .play_btn(play_btn),
    .speaker(speaker),
    .busy(busy),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] spk;
    logic       busy;
    logic [1:0] step;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // playback model state
  bit   m_playing = 1'b0;
  bit   m_btn_prev = 1'b0;
  int   m_n = 0;
  logic [5:0] song = 6'b11_01_10;
  int   hp [2] = '{2, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int k;
    int p;
    logic [1:0] mask;
    e = '0;
    if (m_playing) begin
      k = (m_n / STEP) % NSTEPS;
      p = m_n % STEP;
      mask = 2'((song >> ((NSTEPS - 1 - k) * 2)) & 6'b11);
      for (int v = 0; v < 2; v++)
        e.spk[v] = mask[v] && (p < STEP - GAP) && (((p / hp[v]) % 2) == 1);
      e.busy = 1'b1;
      e.step = 2'(k);
    end
    return e;
  endfunction

  // Drive one cycle of input, advance the model and queue the expected post-edge outputs.
  task automatic drive(input logic b);
    bit r;
    play_btn = b;
    r = b && !m_btn_prev;
    m_btn_prev = b;
    if (!m_playing) begin
      if (r) begin
        m_playing = 1'b1;
        m_n = 0;
      end
    end else if (r) begin
      m_playing = 1'b0;
    end else begin
      m_n++;
      if (!LOOP && m_n == STEP * NSTEPS) m_playing = 1'b0;
    end
    sb_q.push_back(predict());
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  task automatic stop_if_playing();
    if (m_playing) begin
      drive(1'b1);
      drive(1'b0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("speaker", 32'(speaker), 32'(e.spk));
      check("busy", 32'(busy), 32'(e.busy));
      check("step_idx", 32'(step_idx), 32'(e.step));
    end
  end

  initial begin
    #12;
    check("rst_speaker", 32'(speaker), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step", 32'(step_idx), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(3);

    $display("[TB] reset mid-NOTE");
    drive(1'b1);
    idle_cycles(8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_speaker", 32'(speaker), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_step", 32'(step_idx), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_playing = 1'b0;
    m_btn_prev = 1'b0;
    idle_cycles(3);

    $display("[TB] single press, full song");
    drive(1'b1);
    idle_cycles(STEP * NSTEPS + 6);
    stop_if_playing();
    idle_cycles(3);

    $display("[TB] button held high 200 cycles");
    for (int i = 0; i < 200; i++) drive(1'b1);
    drive(1'b0);
    stop_if_playing();
    idle_cycles(3);

    $display("[TB] stop at step1 NOTE cycle 5");
    drive(1'b1);
    idle_cycles(STEP + 5);
    drive(1'b1);
    idle_cycles(10);

    $display("[TB] stop coincident with final GAP last cycle");
    drive(1'b0);
    drive(1'b1);
    idle_cycles(STEP * NSTEPS - 1);
    drive(1'b1);
    idle_cycles(30);

    $display("[TB] loop run (continuous playback if looping enabled)");
    drive(1'b0);
    drive(1'b1);
    idle_cycles(STEP * NSTEPS * 3 + 10);
    stop_if_playing();
    idle_cycles(3);

    @(posedge clk);
    #3;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
